fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/benz_pkg.sv | 29 ++
 rtl/fetch_fifo.sv | 71 +++++++
 rtl/fetch_unit.sv | 182 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/benz_pkg.sv
// ============================================================================
// benz_pkg
//   Shared types and constants for the instruction-fetch path.
//   - word_t        : 32-bit machine word
//   - fetch_entry_t : prefetch buffer entry {pc, instr}
//   - RESET_PC_DEFAULT : default first fetch address after reset
//   - word_align()  : force a byte address down to a word boundary
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package benz_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_entry_t;

  localparam word_t RESET_PC_DEFAULT = 32'h0000_0000;

  function automatic word_t word_align(input word_t addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// fetch_fifo
//   Prefetch buffer holding fetched instruction words with their addresses.
//   Circular buffer of DEPTH entries (DEPTH a power of two), synchronous flush.
//   A simultaneous push and pop is legal when full; the slot being written is
//   the one being released by the pop.
// Ports:
//   clk_50   in   clock
//   rst_n    in   asynchronous active-low reset (buffer cleared, entries zeroed)
//   flush_i  in   empty the buffer at the next edge (overrides push/pop)
//   push_i   in   write data_i at the tail
//   data_i   in   entry to write
//   pop_i    in   release the head entry (caller guarantees non-empty)
//   head_o   out  head entry
//   count_o  out  number of valid entries (0..DEPTH)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_fifo
  import benz_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_50,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  fetch_entry_t             data_i,
  input  logic                     pop_i,
  output fetch_entry_t             head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t    mem_q [DEPTH];
  logic [AW-1:0]   rd_q;
  logic [AW-1:0]   wr_q;
  logic [AW:0]     cnt_q;

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop_i) begin
        rd_q <= rd_q + AW'(1);
      end
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit
//   Instruction fetch front end. Issues sequential word reads to memory under
//   a credit limit (buffered + outstanding < DEPTH), buffers in-order responses
//   in fetch_fifo and presents them to the decoder. A redirect flushes the
//   buffer, restarts fetch at the word-aligned redirect address and drops all
//   responses belonging to requests issued before the redirect.
// Configuration:
//   FETCH_ALIGN_CHECK_EN : when defined, a redirect with redirect_pc[1:0]!=0
//                          sets the sticky fetch_err flag. When undefined,
//                          fetch_err is tied low.
// Ports:
//   clk_50       in   clock
//   rst_n        in   asynchronous active-low reset
//   mem_req      out  word read request (held until mem_gnt)
//   mem_addr     out  request byte address, word aligned
//   mem_gnt      in   request accepted this cycle
//   mem_rvalid   in   read data valid (in request order)
//   mem_rdata    in   read data
//   redirect     in   flush and restart fetch
//   redirect_pc  in   restart address
//   instr_valid  out  instruction available
//   instr        out  instruction word
//   instr_pc     out  address of instr
//   instr_ready  in   decoder consumes when instr_valid && instr_ready
//   fetch_err    out  sticky misaligned-redirect flag
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
  import benz_pkg::*;
#(
  parameter word_t RESET_PC = RESET_PC_DEFAULT,
  parameter int    DEPTH    = 4
) (
  input  logic        clk_50,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        fetch_err
);

  localparam int CW = $clog2(DEPTH) + 1;

  // Request port registers
  logic          req_q,   req_d;
  word_t         addr_q,  addr_d;
  // Next address to issue as a fresh request
  word_t         fpc_q,   fpc_d;
  // Address of the next response that will be kept
  word_t         rpc_q,   rpc_d;
  // Granted requests whose response has not yet arrived (kept or dropped)
  logic [CW-1:0] out_q,   out_d;
  // Responses still to be discarded
  logic [CW-1:0] drop_q,  drop_d;
  // Pending request was issued before a redirect; drop its response on grant
  logic          stale_q, stale_d;

  logic          grant;
  logic          push;
  logic          pop;
  logic          hold;
  word_t         target;
  word_t         fpc_eff;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [CW:0]   used_next;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;

  assign target = word_align(redirect_pc);

  always_comb begin
    grant      = req_q & mem_gnt;
    hold       = req_q & ~mem_gnt;
    pop        = (cnt != '0) & instr_ready;
    // A response arriving together with a redirect belongs to the old stream
    push       = mem_rvalid & (drop_q == '0) & ~redirect;
    push_entry = '{pc: rpc_q, instr: mem_rdata};

    out_d      = out_q + CW'(grant) - CW'(mem_rvalid);
    cnt_next   = redirect ? '0 : (cnt + CW'(push) - CW'(pop));
    used_next  = {1'b0, cnt_next} + {1'b0, out_d};

    fpc_eff    = redirect ? target : fpc_q;
    rpc_d      = redirect ? target : (push ? (rpc_q + 32'd4) : rpc_q);

    if (redirect) begin
      // Every request granted so far (this edge included) returns data that
      // must be dropped; responses already consumed this cycle are excluded
      // by out_d.
      drop_d  = out_d;
      stale_d = hold;
    end else begin
      drop_d  = drop_q - CW'(mem_rvalid && (drop_q != '0)) + CW'(grant && stale_q);
      stale_d = stale_q & ~grant;
    end

    if (hold) begin
      // A pending request keeps its address even across a redirect
      req_d  = 1'b1;
      addr_d = addr_q;
      fpc_d  = fpc_eff;
    end else if (used_next < (CW+1)'(DEPTH)) begin
      req_d  = 1'b1;
      addr_d = fpc_eff;
      fpc_d  = fpc_eff + 32'd4;
    end else begin
      req_d  = 1'b0;
      addr_d = addr_q;
      fpc_d  = fpc_eff;
    end
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      fpc_q   <= RESET_PC;
      rpc_q   <= RESET_PC;
      out_q   <= '0;
      drop_q  <= '0;
      stale_q <= 1'b0;
    end else begin
      req_q   <= req_d;
      addr_q  <= addr_d;
      fpc_q   <= fpc_d;
      rpc_q   <= rpc_d;
      out_q   <= out_d;
      drop_q  <= drop_d;
      stale_q <= stale_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_50  (clk_50),
    .rst_n   (rst_n),
    .flush_i (redirect),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (cnt)
  );

  assign mem_req     = req_q;
  assign mem_addr    = addr_q;
  assign instr_valid = (cnt != '0);
  assign instr       = head.instr;
  assign instr_pc    = head.pc;

`ifdef FETCH_ALIGN_CHECK_EN
  logic err_q;

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
      err_q <= 1'b1;
    end
  end

  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// tb_fetch_unit
//   Self-checking bench for fetch_unit. A memory model grants requests and
//   returns in-order data after a random latency; data is a fixed function of
//   the address. The reference model tracks the expected instruction stream
//   (next pc to consume, next fresh fetch address, sticky error flag) from the
//   architectural rules only.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;

  logic        clk_50 = 1'b0;
  logic        rst_n;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        fetch_err;

  fetch_unit #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk_50      (clk_50),
    .rst_n       (rst_n),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .fetch_err   (fetch_err)
  );

  always #10 clk_50 = ~clk_50;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;

  rsp_t        mq[$];
  int          n_tests;
  int          n_fail;
  int          cyc;
  int          last_due;
  int          grants;
  logic [31:0] exp_pc;
  logic [31:0] exp_fetch;
  logic        exp_err;
  logic        prev_req;
  logic        prev_gnt;
  logic [31:0] prev_addr;
  logic        force_redir;
  logic [31:0] force_pc;
  logic [31:0] last_pc;
  logic        wrap_seen;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: observe at the negedge, then drive the next inputs.
  task automatic run_cycles(input int n, input int gnt_pct, input int lat_max,
                            input int rdy_pct, input int redir_pct, input bit chk_stream);
    for (int k = 0; k < n; k++) begin
      logic [31:0] tgt;
      int          due;
      @(negedge clk_50);
      cyc++;

      if (prev_req && !prev_gnt) begin
        check("hold_req",  {31'b0, mem_req}, 32'd1);
        check("hold_addr", mem_addr, prev_addr);
      end else if (mem_req) begin
        check("fetch_addr", mem_addr, exp_fetch);
        exp_fetch = exp_fetch + 32'd4;
      end
      check("fetch_err", {31'b0, fetch_err}, {31'b0, exp_err});
      if (chk_stream && cyc >= 3) begin
        check("stream_valid", {31'b0, instr_valid}, 32'd1);
      end

      mem_rvalid = 1'b0;
      mem_rdata  = $urandom();
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mdata(mq[0].addr);
        void'(mq.pop_front());
      end

      mem_gnt = (gnt_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < gnt_pct);
      if (mem_req && mem_gnt) begin
        due = cyc + $urandom_range(1, lat_max);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mq.push_back('{addr: mem_addr, due: due});
        grants++;
      end

      instr_ready = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < rdy_pct);
      if (instr_valid && instr_ready) begin
        check("instr_pc", instr_pc, exp_pc);
        check("instr",    instr,    mdata(exp_pc));
        if (instr_pc == 32'h0 && last_pc == 32'hFFFF_FFFC) wrap_seen = 1'b1;
        last_pc = instr_pc;
        exp_pc  = exp_pc + 32'd4;
      end

      redirect    = force_redir || ((redir_pct > 0) && ($urandom_range(0, 99) < redir_pct));
      tgt         = force_redir ? force_pc : ($urandom() & 32'h0000_3FFF);
      redirect_pc = tgt;
      force_redir = 1'b0;
      if (redirect) begin
        exp_pc    = {tgt[31:2], 2'b00};
        exp_fetch = {tgt[31:2], 2'b00};
`ifdef FETCH_ALIGN_CHECK_EN
        if (tgt[1:0] != 2'b00) exp_err = 1'b1;
`endif
      end

      prev_req  = mem_req;
      prev_gnt  = mem_gnt;
      prev_addr = mem_addr;
    end
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mem_req",     {31'b0, mem_req},     32'd0);
    check("rst_mem_addr",    mem_addr,             RESET_PC);
    check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instr",       instr,                32'd0);
    check("rst_instr_pc",    instr_pc,             32'd0);
    check("rst_fetch_err",   {31'b0, fetch_err},   32'd0);
    mq.delete();
    mem_gnt     = 1'b0;
    mem_rvalid  = 1'b0;
    mem_rdata   = '0;
    redirect    = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;
    repeat (2) @(negedge clk_50);
    rst_n     = 1'b1;
    cyc       = 0;
    last_due  = 0;
    grants    = 0;
    exp_pc    = RESET_PC;
    exp_fetch = RESET_PC;
    exp_err   = 1'b0;
    prev_req  = 1'b0;
    prev_gnt  = 1'b0;
    prev_addr = RESET_PC;
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    force_redir = 1'b0;
    force_pc    = '0;
    last_pc     = '0;
    wrap_seen   = 1'b0;
    rst_n       = 1'b1;

    // Reset, then full-rate streaming from cycle 3
    do_reset();
    run_cycles(1, 100, 1, 100, 0, 1'b0);
    check("first_req", {31'b0, mem_req}, 32'd1);
    run_cycles(20, 100, 1, 100, 0, 1'b1);

    // Backpressure: exactly DEPTH grants, head held, then resume
    do_reset();
    run_cycles(12, 100, 1, 0, 0, 1'b0);
    check("bp_grants",    grants, DEPTH);
    check("bp_req_low",   {31'b0, mem_req},     32'd0);
    check("bp_head_pc",   instr_pc,             RESET_PC);
    check("bp_valid",     {31'b0, instr_valid}, 32'd1);
    run_cycles(20, 100, 1, 100, 0, 1'b0);

    // Redirect with several responses in flight
    force_redir = 1'b1;
    force_pc    = 32'h0000_0100;
    run_cycles(40, 100, 3, 100, 0, 1'b0);

    // Misaligned redirect under random grant/ready
    force_redir = 1'b1;
    force_pc    = 32'h0000_0102;
    run_cycles(40, 50, 3, 70, 0, 1'b0);

    // Address wrap
    force_redir = 1'b1;
    force_pc    = 32'hFFFF_FFF4;
    wrap_seen   = 1'b0;
    run_cycles(40, 70, 2, 80, 0, 1'b0);
    check("wrap_seen", {31'b0, wrap_seen}, 32'd1);

    // Random traffic with random redirects and pending-request redirects
    run_cycles(3000, 60, 4, 70, 4, 1'b0);

    // Reset in the middle of traffic, then recover
    do_reset();
    run_cycles(300, 60, 4, 70, 4, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
